alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Execute-issue stage sitting directly upstream of the 32-bit ALU.
- Decodes a MIPS instruction into ALUop, selects and extends operands A/B, and derives the destination register.
- Holds the result in a registered output slot backed by a one-entry skid buffer, with valid/ready on both sides.
- Outputs drive the ALU's A, B and ALUop inputs directly; dest/wen travel alongside to the writeback stage.

Parameters:
- DATA_W, 32, operand width; only 32 is supported.
- ILLEGAL_OP, 3'b000, ALUop emitted for undecodable instructions.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of both held entries
- in_valid  input  1  upstream has an instruction
- in_ready  output  1  stage can accept this cycle
- instr  input  32  instruction word
- rs_value  input  32  GPR[rs]
- rt_value  input  32  GPR[rt]
- out_valid  output  1  alu_a/alu_b/alu_op are valid
- out_ready  input  1  downstream consumes this cycle
- alu_a  output  32  ALU operand A
- alu_b  output  32  ALU operand B
- alu_op  output  3  0 and, 1 or, 2 add, 3 sll, 4 sltiu, 5 lui, 6 sub, 7 slt
- dest  output  5  destination register
- wen  output  1  register write enable
- is_branch  output  1  beq/bne; the consumer uses the ALU Zero flag
- branch_ne  output  1  1 = bne
- illegal  output  1  undecodable instruction

Behaviour:
- Reset (resetn low, asynchronous): out_valid=0, in_ready=1 next edge, skid empty, all data outputs 0.
- Decode is combinational on instr; results are captured on acceptance (in_valid & in_ready).
- R-type (op 0x00), funct:
  - 0x21 addu: op 2, A=rs, B=rt
  - 0x23 subu: op 6, A=rs, B=rt
  - 0x24 and: op 0, A=rs, B=rt
  - 0x25 or: op 1, A=rs, B=rt
  - 0x2a slt: op 7, A=rs, B=rt
  - 0x00 sll: op 3, A={27'b0,instr[10:6]}, B=rt
  - R-type dest=instr[15:11].
- I-type, dest=instr[20:16], imm=instr[15:0]:
  - 0x09 addiu: op 2, A=rs, B=sext(imm)
  - 0x0a slti: op 7, A=rs, B=sext(imm)
  - 0x0b sltiu: op 4, A=rs, B=sext(imm)
  - 0x0c andi: op 0, A=rs, B=zext(imm)
  - 0x0d ori: op 1, A=rs, B=zext(imm)
  - 0x0f lui: op 5, A=0, B=zext(imm)
  - 0x23 lw: op 2, A=rs, B=sext(imm)
  - 0x2b sw: op 2, A=rs, B=sext(imm), wen=0
- Branches: 0x04 beq and 0x05 bne: op 6, A=rs, B=rt, wen=0, is_branch=1, branch_ne=(op==0x05).
- Any other encoding: illegal=1, alu_op=ILLEGAL_OP, A=B=0, wen=0.
- When wen=0, dest=0. When dest==0, wen is forced to 0.
- Latency: one cycle from acceptance to out_valid, provided the main slot is empty or draining.
- Main slot:
  - Loads from input when empty or when out_ready is high.
  - Otherwise holds all outputs stable while out_valid & !out_ready (no glitching).
- Skid slot:
  - Captures an accepted entry when the main slot is valid and out_ready is low.
  - in_ready is registered: in_ready = !skid_valid.
- Drain: when out_ready is high and skid is valid, skid moves to main, and the input is not loaded into main that cycle. skid_valid clears and in_ready rises the next cycle.
- Ordering: strict FIFO; entries are never reordered or duplicated.
- Simultaneous accept and consume with skid empty: the new entry goes to main with no bubble (sustained throughput of 1 per cycle).
- flush: has priority over accept and consume. Next cycle out_valid=0, skid empty, in_ready=1. An instruction offered in the flush cycle is dropped.
- Reset mid-transfer: all held entries are lost; no partial output.

Decomposition:
- Package alu_issue_pkg:
  - opcode/funct localparams
  - ALUop encodings (AND, OR, ADD, SLL, SLTIU, LUI, SUB, SLT)
  - packed entry struct {a, b, op, dest, wen, is_branch, branch_ne, illegal}
- Sub-module alu_issue_decode: purely combinational; instr/rs/rt in, entry struct out.
- Top level holds the main/skid registers and the handshake.

Test Plan:
- addiu $t0,$t1,-1 (0x2528FFFF), rs=5, out_ready=1 -> next cycle out_valid=1, alu_op=2, alu_a=5, alu_b=0xFFFFFFFF, dest=8, wen=1.
- sll $2,$3,4 (0x00031100), rt=0x1 -> alu_op=3, alu_a=4, alu_b=1, dest=2; lui 0x3C011234 -> alu_op=5, alu_a=0, alu_b=0x00001234, dest=1.
- Three back-to-back valid instructions with out_ready=0 -> first in main, second in skid, in_ready=0 from cycle 2, third held off. Raise out_ready -> outputs in order 1,2,3 with no loss.
- beq (0x10850003) -> is_branch=1, branch_ne=0, alu_op=6, wen=0, dest=0; opcode 0x3F -> illegal=1, alu_op=0, wen=0.
- flush asserted with both slots full and in_valid=1 -> next cycle out_valid=0, in_ready=1, the offered instruction never appears.
- resetn pulsed low mid-stream asynchronously -> out_valid=0 immediately; all data outputs 0 until the first post-reset acceptance.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared definitions for the ALU issue stage.
//   - MIPS opcode / funct field values recognised by the decoder
//   - ALUop encodings as seen by the 32-bit ALU
//   - entry_t: one decoded instruction as held in the main/skid slots
package alu_issue_pkg;

    // Primary opcode field, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type funct field, instr[5:0]
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2a;

    typedef enum logic [2:0] {
        ALU_AND   = 3'd0,
        ALU_OR    = 3'd1,
        ALU_ADD   = 3'd2,
        ALU_SLL   = 3'd3,
        ALU_SLTIU = 3'd4,
        ALU_LUI   = 3'd5,
        ALU_SUB   = 3'd6,
        ALU_SLT   = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [4:0]  dest;
        logic        wen;
        logic        is_branch;
        logic        branch_ne;
        logic        illegal;
    } entry_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] v);
        return {16'h0000, v};
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: purely combinational MIPS decoder for the ALU issue stage.
// Ports:
//   instr    in  32  instruction word
//   rs_value in  32  GPR[rs]
//   rt_value in  32  GPR[rt]
//   entry    out     decoded operands, ALUop, destination and flags
module alu_issue_decode
    import alu_issue_pkg::*;
#(
    parameter logic [2:0] ILLEGAL_OP = 3'b000
) (
    input  logic [31:0] instr,
    input  logic [31:0] rs_value,
    input  logic [31:0] rt_value,
    output entry_t      entry
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic        unused_rs_field;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];
    // The rs register number is resolved upstream; only its value arrives here.
    assign unused_rs_field = ^instr[25:21];

    always_comb begin
        entry         = '0;
        entry.op      = ILLEGAL_OP;
        entry.illegal = 1'b1;

        case (opcode)
            OP_RTYPE: begin
                entry.illegal = 1'b0;
                entry.a       = rs_value;
                entry.b       = rt_value;
                entry.dest    = instr[15:11];
                entry.wen     = 1'b1;
                case (funct)
                    FN_ADDU: entry.op = ALU_ADD;
                    FN_SUBU: entry.op = ALU_SUB;
                    FN_AND:  entry.op = ALU_AND;
                    FN_OR:   entry.op = ALU_OR;
                    FN_SLT:  entry.op = ALU_SLT;
                    FN_SLL: begin
                        entry.op = ALU_SLL;
                        entry.a  = {27'b0, instr[10:6]};
                    end
                    default: begin
                        entry         = '0;
                        entry.op      = ILLEGAL_OP;
                        entry.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: begin
                entry.illegal = 1'b0;
                entry.a       = rs_value;
                entry.b       = sext16(imm);
                entry.dest    = instr[20:16];
                entry.wen     = 1'b1;
                case (opcode)
                    OP_SLTI:  entry.op = ALU_SLT;
                    OP_SLTIU: entry.op = ALU_SLTIU;
                    OP_ANDI: begin
                        entry.op = ALU_AND;
                        entry.b  = zext16(imm);
                    end
                    OP_ORI: begin
                        entry.op = ALU_OR;
                        entry.b  = zext16(imm);
                    end
                    OP_LUI: begin
                        entry.op = ALU_LUI;
                        entry.a  = '0;
                        entry.b  = zext16(imm);
                    end
                    OP_SW: begin
                        entry.op  = ALU_ADD;
                        entry.wen = 1'b0;
                    end
                    default: entry.op = ALU_ADD;   // addiu, lw
                endcase
            end
            OP_BEQ, OP_BNE: begin
                entry.illegal   = 1'b0;
                entry.op        = ALU_SUB;
                entry.a         = rs_value;
                entry.b         = rt_value;
                entry.is_branch = 1'b1;
                entry.branch_ne = (opcode == OP_BNE);
            end
            default: ;
        endcase

        // $0 is never written, and a non-writing entry carries no destination.
        if (entry.dest == 5'd0) entry.wen = 1'b0;
        if (!entry.wen) entry.dest = 5'd0;
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: execute-issue stage in front of the 32-bit ALU.
// Decodes the incoming instruction, and holds the result in a registered
// main slot backed by a one-entry skid buffer (valid/ready on both sides).
// Ports:
//   clk, resetn (async, active-low), flush (sync kill of held entries)
//   in_valid/in_ready, instr, rs_value, rt_value   - upstream side
//   out_valid/out_ready                            - downstream side
//   alu_a, alu_b, alu_op                           - ALU operand/opcode inputs
//   dest, wen, is_branch, branch_ne, illegal       - sideband to writeback
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int         DATA_W     = 32,
    parameter logic [2:0] ILLEGAL_OP = 3'b000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_value,
    input  logic [DATA_W-1:0] rt_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    output logic [4:0]        dest,
    output logic              wen,
    output logic              is_branch,
    output logic              branch_ne,
    output logic              illegal
);

    entry_t dec_entry;

    alu_issue_decode #(
        .ILLEGAL_OP(ILLEGAL_OP)
    ) u_decode (
        .instr   (instr),
        .rs_value(rs_value),
        .rt_value(rt_value),
        .entry   (dec_entry)
    );

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_vld_q, main_vld_d;
    logic   skid_vld_q, skid_vld_d;
    logic   in_ready_q, in_ready_d;
    logic   accept;

    assign accept = in_valid & in_ready_q;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;

        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (skid_vld_q) begin
            // in_ready is low while the skid is full, so nothing is accepted here.
            if (out_ready) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_vld_q || out_ready) begin
                main_d     = dec_entry;
                main_vld_d = 1'b1;
            end else begin
                skid_d     = dec_entry;
                skid_vld_d = 1'b1;
            end
        end else if (out_ready) begin
            main_vld_d = 1'b0;
        end

        in_ready_d = !skid_vld_d;
    end

    // ---- main slot / control registers ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
        end
    end

    // ---- skid data (qualified by skid_vld_q, never observed directly) ----
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_vld_q;
    assign alu_a     = main_q.a;
    assign alu_b     = main_q.b;
    assign alu_op    = main_q.op;
    assign dest      = main_q.dest;
    assign wen       = main_q.wen;
    assign is_branch = main_q.is_branch;
    assign branch_ne = main_q.branch_ne;
    assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        resetn, flush, in_valid, in_ready;
    logic [31:0] instr, rs_value, rt_value;
    logic        out_valid, out_ready;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_op;
    logic [4:0]  dest;
    logic        wen, is_branch, branch_ne, illegal;

    alu_issue dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_value(rs_value), .rt_value(rt_value),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .dest(dest), .wen(wen), .is_branch(is_branch),
        .branch_ne(branch_ne), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [4:0]  dest;
        logic        wen;
        logic        br;
        logic        bne;
        logic        ill;
    } exp_t;

    exp_t q[$];          // entries held by the stage, oldest first
    int   n_chk = 0;
    int   n_err = 0;
    logic zero_hold;     // true from reset until the first acceptance

    logic [5:0] fn_tab [6] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h00};
    logic [5:0] op_tab [8] = '{6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference decoder straight from the instruction tables.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] rs,
                                        input logic [31:0] rt);
        exp_t e;
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [31:0] sx, zx;
        opc = ins[31:26];
        fn  = ins[5:0];
        sx  = {{16{ins[15]}}, ins[15:0]};
        zx  = {16'h0, ins[15:0]};
        e   = '0;
        e.ill = 1'b1;
        if (opc == 6'h00) begin
            e = '{a: rs, b: rt, op: 3'd0, dest: ins[15:11], wen: 1'b1, br: 1'b0, bne: 1'b0, ill: 1'b0};
            if (fn == 6'h21) e.op = 3'd2;
            else if (fn == 6'h23) e.op = 3'd6;
            else if (fn == 6'h24) e.op = 3'd0;
            else if (fn == 6'h25) e.op = 3'd1;
            else if (fn == 6'h2a) e.op = 3'd7;
            else if (fn == 6'h00) begin e.op = 3'd3; e.a = 32'(ins[10:6]); end
            else begin e = '0; e.ill = 1'b1; end
        end else if (opc == 6'h04 || opc == 6'h05) begin
            e = '{a: rs, b: rt, op: 3'd6, dest: 5'd0, wen: 1'b0, br: 1'b1,
                  bne: (opc == 6'h05), ill: 1'b0};
        end else begin
            e.ill = 1'b0; e.dest = ins[20:16]; e.wen = 1'b1; e.a = rs;
            case (opc)
                6'h09, 6'h23: begin e.op = 3'd2; e.b = sx; end
                6'h2b:        begin e.op = 3'd2; e.b = sx; e.wen = 1'b0; end
                6'h0a:        begin e.op = 3'd7; e.b = sx; end
                6'h0b:        begin e.op = 3'd4; e.b = sx; end
                6'h0c:        begin e.op = 3'd0; e.b = zx; end
                6'h0d:        begin e.op = 3'd1; e.b = zx; end
                6'h0f:        begin e.op = 3'd5; e.b = zx; e.a = 32'd0; end
                default:      begin e = '0; e.ill = 1'b1; end
            endcase
        end
        if (!e.wen || e.dest == 5'd0) begin
            e.wen  = 1'b0;
            e.dest = 5'd0;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom();
        k = $urandom_range(0, 17);
        if (k < 6) begin
            w[31:26] = 6'h00; w[5:0] = fn_tab[k];
        end else if (k < 14) begin
            w[31:26] = op_tab[k-6];
        end else if (k == 14) w[31:26] = 6'h04;
        else if (k == 15) w[31:26] = 6'h05;
        else if (k == 16) w[31:26] = 6'h3f;
        else begin w[31:26] = 6'h00; w[5:0] = 6'h3f; end
        return w;
    endfunction

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            chk("alu_a", alu_a, q[0].a);
            chk("alu_b", alu_b, q[0].b);
            chk("alu_op", 32'(alu_op), 32'(q[0].op));
            chk("dest", 32'(dest), 32'(q[0].dest));
            chk("flags", {28'd0, wen, is_branch, branch_ne, illegal},
                {28'd0, q[0].wen, q[0].br, q[0].bne, q[0].ill});
        end else if (zero_hold) begin
            chk("zero_data", alu_a | alu_b | 32'(alu_op) | 32'(dest) |
                32'({wen, is_branch, branch_ne, illegal}), 32'd0);
        end
    endtask

    // One clock: drive inputs, advance the occupancy model at the edge, check.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                        input logic [31:0] rt, input logic ordy, input logic fl);
        logic acc, cons;
        exp_t e;
        in_valid = v; instr = ins; rs_value = rs; rt_value = rt;
        out_ready = ordy; flush = fl;
        acc  = v && in_ready && !fl;
        cons = out_valid && ordy && !fl;
        e    = ref_decode(ins, rs, rt);
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (cons && q.size() > 0) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        if (acc) zero_hold = 1'b0;
        #1;
        check_outputs();
    endtask

    task automatic async_reset();
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_side", {24'd0, alu_op, dest}, 32'd0);
        chk("rst_flags", {28'd0, wen, is_branch, branch_ne, illegal}, 32'd0);
        q.delete();
        zero_hold = 1'b1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; rs_value = '0; rt_value = '0;
        zero_hold = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_alu_a", alu_a, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        // addiu $t0,$t1,-1
        step(1'b1, 32'h2528FFFF, 32'd5, 32'd0, 1'b1, 1'b0);
        chk("addiu_valid", 32'(out_valid), 32'd1);
        chk("addiu_op", 32'(alu_op), 32'd2);
        chk("addiu_a", alu_a, 32'd5);
        chk("addiu_b", alu_b, 32'hFFFFFFFF);
        chk("addiu_dest", {26'd0, dest, wen}, {26'd0, 5'd8, 1'b1});
        // sll $2,$3,4
        step(1'b1, 32'h00031100, 32'd0, 32'h1, 1'b1, 1'b0);
        chk("sll_op", 32'(alu_op), 32'd3);
        chk("sll_ab", {alu_a[15:0], alu_b[15:0]}, {16'd4, 16'd1});
        chk("sll_dest", 32'(dest), 32'd2);
        // lui $1,0x1234
        step(1'b1, 32'h3C011234, 32'h77, 32'h0, 1'b1, 1'b0);
        chk("lui_op", 32'(alu_op), 32'd5);
        chk("lui_a", alu_a, 32'd0);
        chk("lui_b", alu_b, 32'h00001234);
        chk("lui_dest", 32'(dest), 32'd1);
        // beq
        step(1'b1, 32'h10850003, 32'h9, 32'h9, 1'b1, 1'b0);
        chk("beq_flags", {28'd0, wen, is_branch, branch_ne, illegal}, 32'b0100);
        chk("beq_op_dest", {24'd0, alu_op, dest}, {24'd0, 3'd6, 5'd0});
        // opcode 0x3F
        step(1'b1, 32'hFC000000 | 32'h00421020, 32'h5, 32'h6, 1'b1, 1'b0);
        chk("ill_flags", {28'd0, wen, is_branch, branch_ne, illegal}, 32'b0001);
        chk("ill_op", 32'(alu_op), 32'd0);
        chk("ill_ab", alu_a | alu_b, 32'd0);
        step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Three back-to-back with downstream stalled
        step(1'b1, 32'h24010001, 32'd10, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'h24020002, 32'd20, 32'd0, 1'b0, 1'b0);
        chk("skid_full_in_ready", 32'(in_ready), 32'd0);
        step(1'b1, 32'h24030003, 32'd30, 32'd0, 1'b0, 1'b0);
        chk("third_held_dest", 32'(dest), 32'd1);
        step(1'b1, 32'h24030003, 32'd30, 32'd0, 1'b1, 1'b0);
        chk("drain_second", 32'(dest), 32'd2);
        step(1'b1, 32'h24030003, 32'd30, 32'd0, 1'b1, 1'b0);
        chk("drain_third", 32'(dest), 32'd3);
        step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Flush with both slots full and an instruction on offer
        step(1'b1, 32'h24040004, 32'd1, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'h24050005, 32'd2, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'h24060006, 32'd3, 32'd0, 1'b0, 1'b1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("flush_dropped", 32'(out_valid), 32'd0);

        // Randomised traffic with an asynchronous reset partway through
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom(), $urandom(),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
            if (i == 700) async_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
